// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 scan timing constants, the packed pixel colour type
// and the divide-by-255 helper used when alpha blending is compiled in.
package vga_pkg;

  localparam logic [9:0] H_VIS  = 10'd640;
  localparam logic [9:0] H_FP   = 10'd16;
  localparam logic [9:0] H_SYNC = 10'd96;
  localparam logic [9:0] H_BP   = 10'd48;
  localparam logic [9:0] H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;

  localparam logic [9:0] V_VIS  = 10'd480;
  localparam logic [9:0] V_FP   = 10'd10;
  localparam logic [9:0] V_SYNC = 10'd2;
  localparam logic [9:0] V_BP   = 10'd33;
  localparam logic [9:0] V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Rounded x/255 without a divider; exact over the 0..255*255 blend range.
  function automatic logic [7:0] div255(input logic [15:0] x);
    logic [16:0] t;
    t = 17'(x) + 17'd128;
    return 8'((t + (t >> 4'd8)) >> 4'd8);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel-enable flop (25 MHz from 50 MHz), 800x525 scan
// counters, and sync / visible / blanking decode of the current position.
module vga_timing
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic [9:0] h_nxt,
  output logic [9:0] v_nxt,
  output logic       h_sync_dec,
  output logic       v_sync_dec,
  output logic       visible,
  output logic       vblank_dec
);

  // Next scan position: counters only move on the edge that ends cycle B.
  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (pix_en) begin
      if (h_cnt == H_TOT - 10'd1) begin
        h_nxt = 10'd0;
        v_nxt = (v_cnt == V_TOT - 10'd1) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_nxt = h_cnt + 10'd1;
      end
    end else begin
      h_nxt = h_cnt;
      v_nxt = v_cnt;
    end
  end

  // Pixel phase toggle and scan counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_en <= 1'b0;
      h_cnt  <= 10'd0;
      v_cnt  <= 10'd0;
    end else begin
      pix_en <= ~pix_en;
      h_cnt  <= h_nxt;
      v_cnt  <= v_nxt;
    end
  end

  // Decode of the current position; syncs are active low.
  always_comb begin
    h_sync_dec = !((h_cnt >= H_VIS + H_FP) && (h_cnt < H_VIS + H_FP + H_SYNC));
    v_sync_dec = !((v_cnt >= V_VIS + V_FP) && (v_cnt < V_VIS + V_FP + V_SYNC));
    visible    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    vblank_dec = (v_cnt >= V_VIS);
  end

endmodule

// File: rtl/vga_frame_reader.sv
// vga_frame_reader: scans an IMG_W x IMG_H framebuffer centred on a black
// border and drives 640x480@60 VGA pins. Defining VGA_ALPHA_BLEND_EN adds
// an alpha-blend stage against BG_RGB and one more pixel period of lag.
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       PIX_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h0000_1000),
  parameter int unsigned       IMG_W     = 256,
  parameter int unsigned       IMG_H     = 256,
  parameter int unsigned       X_OFF     = 192,
  parameter int unsigned       Y_OFF     = 112,
  parameter logic [23:0]       BG_RGB    = 24'h000000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              fb_rd_en,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [PIX_W-1:0]  fb_rdata,
  output logic [23:0]       rgb,
  output logic              h_sync,
  output logic              v_sync,
  output logic              vga_clk,
  output logic              vblank
);

  localparam int unsigned IMG_SH = $clog2(IMG_W);
  localparam logic [10:0] X_LO   = 11'(X_OFF);
  localparam logic [10:0] X_HI   = 11'(X_OFF + IMG_W);
  localparam logic [10:0] Y_LO   = 11'(Y_OFF);
  localparam logic [10:0] Y_HI   = 11'(Y_OFF + IMG_H);

  logic              pix_en;
  logic [9:0]        h_cnt, v_cnt, h_nxt, v_nxt;
  logic              h_sync_dec, v_sync_dec, visible, vblank_dec;
  logic              in_img_cur, in_img_nxt;
  logic [ADDR_W-1:0] addr_nxt;

  vga_timing u_timing (
    .clk        (clk),
    .rst        (rst),
    .pix_en     (pix_en),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .h_nxt      (h_nxt),
    .v_nxt      (v_nxt),
    .h_sync_dec (h_sync_dec),
    .v_sync_dec (v_sync_dec),
    .visible    (visible),
    .vblank_dec (vblank_dec)
  );

  assign vga_clk = pix_en;

  function automatic logic in_rect(input logic [9:0] h, input logic [9:0] v);
    return ({1'b0, h} >= X_LO) && ({1'b0, h} < X_HI) &&
           ({1'b0, v} >= Y_LO) && ({1'b0, v} < Y_HI);
  endfunction

  // Image window for the pixel on screen now and the one starting next edge.
  always_comb begin
    in_img_cur = visible && in_rect(h_cnt, v_cnt);
    in_img_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS) && in_rect(h_nxt, v_nxt);
    addr_nxt   = BASE_ADDR
               + (ADDR_W'(v_nxt - Y_LO[9:0]) << IMG_SH)
               + ADDR_W'(h_nxt - X_LO[9:0]);
  end

  // Issue one read in cycle A of every image pixel; address held through A.
  always_ff @(posedge clk) begin
    if (rst) begin
      fb_rd_en <= 1'b0;
      fb_addr  <= {ADDR_W{1'b0}};
    end else if (pix_en) begin
      fb_rd_en <= in_img_nxt;
      fb_addr  <= in_img_nxt ? addr_nxt : fb_addr;
    end else begin
      fb_rd_en <= 1'b0;
    end
  end

`ifdef VGA_ALPHA_BLEND_EN
  logic [PIX_W-1:0] pix_q;
  logic             img_q, hs_q, vs_q, vb_q;
  rgb_t             src, bg, mix, mixed;
  logic [7:0]       alpha, inv;

  // First stage: capture fetched word with its matching sync/blank decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q <= {PIX_W{1'b0}};
      img_q <= 1'b0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      vb_q  <= 1'b0;
    end else if (pix_en) begin
      pix_q <= fb_rdata;
      img_q <= in_img_cur;
      hs_q  <= h_sync_dec;
      vs_q  <= v_sync_dec;
      vb_q  <= vblank_dec;
    end
  end

  // Per-channel blend c*A + BG*(255-A), scaled back by 1/255.
  always_comb begin
    src   = rgb_t'(pix_q[23:0]);
    bg    = rgb_t'(BG_RGB);
    alpha = pix_q[31:24];
    inv   = 8'hFF - alpha;
    mix.r = div255(16'(src.r) * 16'(alpha) + 16'(bg.r) * 16'(inv));
    mix.g = div255(16'(src.g) * 16'(alpha) + 16'(bg.g) * 16'(inv));
    mix.b = div255(16'(src.b) * 16'(alpha) + 16'(bg.b) * 16'(inv));
    mixed = img_q ? mix : rgb_t'(24'h000000);
  end

  // Output stage: blended colour and syncs move together on vga_clk fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb    <= 24'h000000;
      h_sync <= 1'b1;
      v_sync <= 1'b1;
      vblank <= 1'b0;
    end else if (pix_en) begin
      rgb    <= mixed;
      h_sync <= hs_q;
      v_sync <= vs_q;
      vblank <= vb_q;
    end
  end
`else
  logic unused_bits;
  assign unused_bits = ^{fb_rdata[PIX_W-1:24], BG_RGB};

  // Output stage: colour and syncs move together on vga_clk fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb    <= 24'h000000;
      h_sync <= 1'b1;
      v_sync <= 1'b1;
      vblank <= 1'b0;
    end else if (pix_en) begin
      rgb    <= in_img_cur ? fb_rdata[23:0] : 24'h000000;
      h_sync <= h_sync_dec;
      v_sync <= v_sync_dec;
      vblank <= vblank_dec;
    end
  end
`endif

endmodule
